rs_seg_pipe_adder: RTL and testbench
====================================

Name: rs_seg_pipe_adder

Overview:
- Pipelined wide add/subtract unit for genesis3 arithmetic operands wider than one carry chain.
- Splits a WIDTH-bit operation into SEG_WIDTH-bit segments and inserts one register stage per segment, so no combinational chain exceeds `MAX_CARRY_CHAIN`.
- Each segment adder is inferred as an `$alu` that maps onto adder_carry.
- Streams operands in and results out over a valid/ready handshake.

Parameters:
- WIDTH, 64, operand and result width in bits (≥1).
- SEG_WIDTH, 32, bits per segment; must be 3..`MAX_CARRY_CHAIN`. Elaboration error otherwise.
- NSEG, derived ceil(WIDTH/SEG_WIDTH), number of pipeline stages. The last segment may be narrower. Not user-set.

Ports:
- C  input  1  clock, rising edge.
- R  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  unit accepts a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  0: a+b+cin; 1: a−b−cin (cin acts as borrow-in).
- cin  input  1  carry/borrow in.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  raw carry out of bit WIDTH−1. For sub, 1 means no borrow.
- overflow  output  1  signed overflow (carry into MSB XOR carry out of MSB).

Behaviour:
- Reset (R low, async): all stage valid bits 0, out_valid=0, sum=0, cout=0, overflow=0. in_ready=1 after reset deasserts.
- Operand pre-processing at input:
  - bb = sub ? ~b : b
  - c0 = sub ? ~cin : cin
  - This matches `$alu` BI/CI semantics.
- Stage k (0..NSEG−1) registers:
  - segment k of the sum: a_seg + bb_seg + carry_k.
  - carry_k+1.
  - valid bit.
  - remaining upper operand segments, delayed.
  - lower sum segments, delayed, for alignment.
- Stage 0 uses c0. Stage k>0 uses the registered carry of stage k−1.
- Latency: exactly NSEG cycles from accepted beat to out_valid, with no stall.
- Throughput: one beat per cycle.
- Stall rule:
  - advance = ~out_valid | out_ready.
  - in_ready = advance.
  - All stages shift together when advance=1 and hold otherwise.
  - Bubbles are not collapsed.
- Accept when in_valid & in_ready. A beat presented while in_ready=0 is not consumed; the source holds it.
- Stability: sum, cout and overflow change only on a register update. While out_valid=1 & out_ready=0 they are stable.
- cout and overflow are computed in the final stage only:
  - carry into MSB = carry into bit WIDTH−1 of the last segment.
  - For a 1-bit last segment this is that stage's carry-in.
- NSEG=1: single registered stage, latency 1.
- Reset mid-operation discards all in-flight beats. No output beat is produced for them.
- Simultaneous out_ready=1 and new in_valid on a full pipe: the output is retired and the input is accepted in the same cycle.

Test Plan:
- WIDTH=64, SEG=32, a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1, sub=0 -> after exactly 2 cycles sum=0, cout=1, overflow=0.
- sub=1, a=0, b=1, cin=0 -> sum=0xFFFF_FFFF_FFFF_FFFF, cout=0, overflow=0. Also a=0x8000_0000_0000_0000, b=1 -> sum=0x7FFF_FFFF_FFFF_FFFF, overflow=1.
- a=0x7FFF_FFFF_FFFF_FFFF, b=1, sub=0, cin=0 -> sum=0x8000_0000_0000_0000, overflow=1, cout=0.
- Backpressure: 4 back-to-back beats (1+1, 2+2, 3+3, 4+4) with out_ready=0 from cycle 1 -> in_ready drops to 0, outputs held stable. After out_ready=1: results 2, 4, 6, 8 in order, none lost or duplicated.
- WIDTH=40, SEG=32 (narrow last segment): a=0xFF_FFFF_FFFF, b=0, cin=1 -> sum=0, cout=1 after 2 cycles.
- Assert R low while 2 beats are in flight -> out_valid=0 immediately (async). After release, no stale beat appears and the next beat has latency NSEG.

Source files
------------

// File: rtl/rs_seg_pipe_adder_if.sv
// Operand/result stream bundle for rs_seg_pipe_adder: valid/ready operand beat in,
// valid/ready result beat out.
interface rs_seg_pipe_adder_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output in_valid, a, b, sub, cin, out_ready,
        input  in_ready, out_valid, sum, cout, overflow
    );

    modport slave (
        input  in_valid, a, b, sub, cin, out_ready,
        output in_ready, out_valid, sum, cout, overflow
    );
endinterface

// File: rtl/rs_seg_pipe_adder.sv
// Segmented pipelined add/subtract: one SEG_WIDTH-bit carry chain per register stage,
// carry forwarded stage to stage, whole pipe stalls together on result backpressure.
`ifndef MAX_CARRY_CHAIN
`define MAX_CARRY_CHAIN 64
`endif

module rs_seg_pipe_adder #(
    parameter int WIDTH     = 64,
    parameter int SEG_WIDTH = 32
) (
    input  logic                C,
    input  logic                R,
    rs_seg_pipe_adder_if.slave  bus
);
    localparam int NSEG = (WIDTH + SEG_WIDTH - 1) / SEG_WIDTH;

    if (WIDTH < 1) begin : g_chk_width
        $error("rs_seg_pipe_adder: WIDTH must be at least 1");
    end
    if (SEG_WIDTH < 3 || SEG_WIDTH > `MAX_CARRY_CHAIN) begin : g_chk_seg
        $error("rs_seg_pipe_adder: SEG_WIDTH must lie in 3..MAX_CARRY_CHAIN");
    end

    // Per stage: x_q holds finished sum segments below the stage boundary and the
    // still-pending A bits above it; y_q carries the (possibly inverted) B operand.
    logic [WIDTH-1:0] x_q   [NSEG];
    logic [WIDTH-1:0] y_q   [NSEG];
    logic             c_q   [NSEG];
    logic             vld_q [NSEG];
    logic             ovf_q;

    logic [WIDTH-1:0] bb;
    logic             c0;
    logic             advance;

    // Subtraction as a + ~b + ~cin, so cin behaves as a borrow-in.
    assign bb      = bus.sub ? ~bus.b : bus.b;
    assign c0      = bus.sub ? ~bus.cin : bus.cin;
    assign advance = ~vld_q[NSEG-1] | bus.out_ready;

    assign bus.in_ready  = advance;
    assign bus.out_valid = vld_q[NSEG-1];
    assign bus.sum       = x_q[NSEG-1];
    assign bus.cout      = c_q[NSEG-1];
    assign bus.overflow  = ovf_q;

    for (genvar k = 0; k < NSEG; k++) begin : g_stg
        localparam int LO = k * SEG_WIDTH;
        localparam int SW = (WIDTH - LO < SEG_WIDTH) ? (WIDTH - LO) : SEG_WIDTH;

        logic [WIDTH-1:0] x_in;
        logic [WIDTH-1:0] y_in;
        logic [WIDTH-1:0] x_d;
        logic             c_in;
        logic             v_in;
        logic [SW:0]      seg_d;

        if (k == 0) begin : g_head
            assign x_in = bus.a;
            assign y_in = bb;
            assign c_in = c0;
            assign v_in = bus.in_valid;
        end else begin : g_body
            assign x_in = x_q[k-1];
            assign y_in = y_q[k-1];
            assign c_in = c_q[k-1];
            assign v_in = vld_q[k-1];
        end

        assign seg_d = {1'b0, x_in[LO +: SW]} + {1'b0, y_in[LO +: SW]} + {{SW{1'b0}}, c_in};

        always_comb begin
            x_d            = x_in;
            x_d[LO +: SW]  = seg_d[SW-1:0];
        end

        always_ff @(posedge C or negedge R) begin
            if (!R) begin
                vld_q[k] <= 1'b0;
                x_q[k]   <= '0;
                y_q[k]   <= '0;
                c_q[k]   <= 1'b0;
            end else if (advance) begin
                vld_q[k] <= v_in;
                x_q[k]   <= x_d;
                y_q[k]   <= y_in;
                c_q[k]   <= seg_d[SW];
            end
        end

        if (k == NSEG - 1) begin : g_tail
            // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ c_msb.
            logic msb_c;
            assign msb_c = x_in[WIDTH-1] ^ y_in[WIDTH-1] ^ seg_d[SW-1];

            always_ff @(posedge C or negedge R) begin
                if (!R) begin
                    ovf_q <= 1'b0;
                end else if (advance) begin
                    ovf_q <= msb_c ^ seg_d[SW];
                end
            end
        end
    end
endmodule

// File: tb/tb_rs_seg_pipe_adder.sv
// Scoreboard bench for rs_seg_pipe_adder: 64/32 and 40/32 instances, directed corner
// vectors, backpressure, async reset flush and randomized traffic.
module tb_rs_seg_pipe_adder;
    logic C = 1'b0;
    logic R = 1'b0;
    always #5 C = ~C;

    rs_seg_pipe_adder_if #(.WIDTH(64)) i64 ();
    rs_seg_pipe_adder_if #(.WIDTH(40)) i40 ();

    rs_seg_pipe_adder #(.WIDTH(64), .SEG_WIDTH(32)) u64 (.C(C), .R(R), .bus(i64));
    rs_seg_pipe_adder #(.WIDTH(40), .SEG_WIDTH(32)) u40 (.C(C), .R(R), .bus(i40));

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    exp_t q64[$];
    exp_t q40[$];
    int   tests  = 0;
    int   fails  = 0;
    int   pops64 = 0;
    int   pops40 = 0;
    bit   rnd_rdy = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: integer add/sub of the W-bit operands, carry from unsigned range,
    // overflow from the signed range.
    function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                   input bit sub, input bit cin);
        exp_t               r;
        logic [63:0]        mask;
        logic [71:0]        ua, ub, ur, t;
        logic signed [71:0] sa, sb, sc, sr, mx, mn;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        ua = {8'd0, a & mask};
        ub = {8'd0, b & mask};
        t  = ua << (72 - w);
        sa = signed'(t) >>> (72 - w);
        t  = ub << (72 - w);
        sb = signed'(t) >>> (72 - w);
        sc = {71'd0, cin};
        if (!sub) begin
            ur     = ua + ub + {71'd0, cin};
            r.cout = ur[w];
            sr     = sa + sb + sc;
        end else begin
            ur     = ua - ub - {71'd0, cin};
            r.cout = (ua >= ub + {71'd0, cin});
            sr     = sa - sb - sc;
        end
        r.sum = ur[63:0] & mask;
        mx    = (72'sd1 <<< (w - 1)) - 72'sd1;
        mn    = -(72'sd1 <<< (w - 1));
        r.ovf = (sr > mx) || (sr < mn);
        return r;
    endfunction

    always @(negedge C) begin
        if (R && i64.out_valid) begin
            if (q64.size() == 0) begin
                chk("u64 out_valid with empty scoreboard", 64'(i64.out_valid), 64'd0);
            end else begin
                chk("u64 sum", i64.sum, q64[0].sum);
                chk("u64 cout", 64'(i64.cout), 64'(q64[0].cout));
                chk("u64 overflow", 64'(i64.overflow), 64'(q64[0].ovf));
                if (i64.out_ready) begin
                    void'(q64.pop_front());
                    pops64++;
                end
            end
        end
    end

    always @(negedge C) begin
        if (R && i40.out_valid) begin
            if (q40.size() == 0) begin
                chk("u40 out_valid with empty scoreboard", 64'(i40.out_valid), 64'd0);
            end else begin
                chk("u40 sum", 64'(i40.sum), q40[0].sum);
                chk("u40 cout", 64'(i40.cout), 64'(q40[0].cout));
                chk("u40 overflow", 64'(i40.overflow), 64'(q40[0].ovf));
                if (i40.out_ready) begin
                    void'(q40.pop_front());
                    pops40++;
                end
            end
        end
    end

    always @(posedge C) begin
        if (rnd_rdy) begin
            #1;
            i64.out_ready = ($urandom_range(0, 3) != 0);
            i40.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic tick();
        @(posedge C);
        #1;
    endtask

    // Called just after a rising edge; returns just after the edge that took the beat.
    task automatic send(input bit sel, input logic [63:0] a, input logic [63:0] b,
                        input bit sub, input bit cin);
        exp_t e;
        e = model(sel ? 40 : 64, a, b, sub, cin);
        if (!sel) begin
            i64.a = a; i64.b = b; i64.sub = sub; i64.cin = cin; i64.in_valid = 1'b1;
        end else begin
            i40.a = a[39:0]; i40.b = b[39:0]; i40.sub = sub; i40.cin = cin; i40.in_valid = 1'b1;
        end
        for (int n = 0; ; n++) begin
            @(negedge C);
            if (sel ? i40.in_ready : i64.in_ready) begin
                if (sel) q40.push_back(e);
                else     q64.push_back(e);
                break;
            end
            if (n >= 300) begin
                chk("send timeout in_ready", 64'(sel ? i40.in_ready : i64.in_ready), 64'd1);
                break;
            end
        end
        tick();
        if (sel) i40.in_valid = 1'b0;
        else     i64.in_valid = 1'b0;
    endtask

    task automatic lat_check(input bit sel, input int n);
        for (int i = 1; i <= n; i++) begin
            @(negedge C);
            chk(sel ? "u40 latency out_valid" : "u64 latency out_valid",
                64'(sel ? i40.out_valid : i64.out_valid), 64'(i == n));
        end
        tick();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q64.size() + q40.size()) != 0 && n < 2000) begin
            tick();
            n++;
        end
        chk("drain pending beats", 64'(q64.size() + q40.size()), 64'd0);
    endtask

    function automatic logic [63:0] rnd_op();
        case ($urandom_range(0, 6))
            0:       return '1;
            1:       return 64'd0;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'h7FFF_FFFF_FFFF_FFFF;
            4:       return 64'h0000_0080_0000_0000 | 64'($urandom_range(0, 3));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        int p;
        i64.in_valid = 1'b0; i64.a = '0; i64.b = '0; i64.sub = 1'b0; i64.cin = 1'b0; i64.out_ready = 1'b0;
        i40.in_valid = 1'b0; i40.a = '0; i40.b = '0; i40.sub = 1'b0; i40.cin = 1'b0; i40.out_ready = 1'b0;
        R = 1'b0;
        repeat (2) @(posedge C);
        #1;
        chk("reset out_valid", 64'(i64.out_valid), 64'd0);
        chk("reset sum", i64.sum, 64'd0);
        chk("reset cout", 64'(i64.cout), 64'd0);
        chk("reset overflow", 64'(i64.overflow), 64'd0);
        chk("reset u40 out_valid", 64'(i40.out_valid), 64'd0);
        R = 1'b1;
        #1;
        chk("in_ready after reset", 64'(i64.in_ready), 64'd1);
        chk("u40 in_ready after reset", 64'(i40.in_ready), 64'd1);
        i64.out_ready = 1'b1;
        i40.out_ready = 1'b1;
        tick();

        // Directed corners, each into an empty pipe to observe the bare latency.
        send(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b1); lat_check(0, 2);
        send(0, 64'd0, 64'd1, 1'b1, 1'b0);                   lat_check(0, 2);
        send(0, 64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0); lat_check(0, 2);
        send(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0); lat_check(0, 2);
        send(1, 64'h00FF_FFFF_FFFF, 64'd0, 1'b0, 1'b1);      lat_check(1, 2);
        drain();

        // Backpressure: four beats with the sink stalled, then released.
        i64.out_ready = 1'b0;
        p = pops64;
        fork
            begin
                for (int i = 1; i <= 4; i++) send(0, 64'(i), 64'(i), 1'b0, 1'b0);
            end
            begin
                repeat (4) tick();
                chk("bp in_ready stalled", 64'(i64.in_ready), 64'd0);
                chk("bp out_valid held", 64'(i64.out_valid), 64'd1);
                repeat (2) tick();
                i64.out_ready = 1'b1;
            end
        join
        drain();
        chk("bp beats retired", 64'(pops64 - p), 64'd4);

        // Randomized traffic with random sink stalls on both instances.
        rnd_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            bit sel;
            sel = 1'($urandom_range(0, 1));
            send(sel, rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) tick();
        end
        rnd_rdy = 1'b0;
        repeat (2) tick();
        i64.out_ready = 1'b1;
        i40.out_ready = 1'b1;
        drain();

        // Asynchronous reset with two beats in flight.
        i64.out_ready = 1'b0;
        send(0, 64'd5, 64'd6, 1'b0, 1'b0);
        send(0, 64'd7, 64'd8, 1'b0, 1'b0);
        #2;
        R = 1'b0;
        #1;
        chk("async reset out_valid", 64'(i64.out_valid), 64'd0);
        chk("async reset sum", i64.sum, 64'd0);
        q64.delete();
        @(posedge C);
        #1;
        R = 1'b1;
        i64.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge C);
            chk("no stale beat after reset", 64'(i64.out_valid), 64'd0);
        end
        tick();
        send(0, 64'h1234, 64'd1, 1'b1, 1'b1);
        lat_check(0, 2);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
